// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the writeback stage.
//   - default widths and the starvation limit
//   - index of the hard-wired zero register
//   - arbitration winner encoding
//   - saturating increment helper for the starvation counter
package wb_stage_pkg;

  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_RD_WIDTH      = 5;
  localparam int WB_STARVE_LIMIT  = 4;
  // Wide enough for any starvation limit in 1..15.
  localparam int STARVE_CNT_WIDTH = 4;
  // Register 0 is hard-wired to zero; it is never written and never busy.
  localparam int REG_ZERO         = 0;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_ALU  = 2'd1,
    WIN_LONG = 2'd2
  } wb_winner_e;

  // Increment that stops at the given limit.
  function automatic logic [STARVE_CNT_WIDTH-1:0] starve_inc(
    input logic [STARVE_CNT_WIDTH-1:0] cnt,
    input logic [STARVE_CNT_WIDTH-1:0] limit
  );
    if (cnt < limit) begin
      starve_inc = cnt + {{(STARVE_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      starve_inc = limit;
    end
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits for outstanding long-latency ops.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_long/issue_rd DEC issues a long-latency op to issue_rd
//   clr_valid/clr_rd    long result accepted for clr_rd (frees the register)
//   rs1, rs2            DEC source indices
//   dec_stall           RAW hazard on rs1/rs2 or WAW hazard on issue_rd
module wb_scoreboard
  import wb_stage_pkg::*;
#(
  parameter int RD_WIDTH = WB_RD_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_long,
  input  logic [RD_WIDTH-1:0] issue_rd,
  input  logic                clr_valid,
  input  logic [RD_WIDTH-1:0] clr_rd,
  input  logic [RD_WIDTH-1:0] rs1,
  input  logic [RD_WIDTH-1:0] rs2,
  output logic                dec_stall
);

  localparam int NUM_REGS = 1 << RD_WIDTH;
  localparam logic [RD_WIDTH-1:0] RD_ZERO = RD_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic                stall_s;
  logic                set_s;

  // Hazard lookup; an issue is only real when DEC is not stalled.
  always_comb begin
    stall_s = busy_r[rs1] | busy_r[rs2] | (issue_long & busy_r[issue_rd]);
    set_s   = issue_long & ~stall_s & (issue_rd != RD_ZERO);
  end

  // Next busy vector: set beats clear on the same index, bit 0 stays clear.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == REG_ZERO) begin
        busy_nxt_s[i] = 1'b0;
      end else if (set_s && (issue_rd == RD_WIDTH'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (clr_valid && (clr_rd == RD_WIDTH'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign dec_stall = stall_s;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage in front of the general purpose register file.
// Ports:
//   cpu_clk, cpu_rst          clock, asynchronous active-high reset
//   alu_*                     single-cycle ALU result (valid/rd/data/ready)
//   long_*                    long-latency result, held until accepted
//   issue_long, issue_rd      DEC issue of a long-latency op
//   rs1_dec, rs2_dec          DEC source indices
//   gprs_data1/2              raw register-file read data
//   src1_data, src2_data      operands with the in-flight WB value bypassed
//   dec_stall                 DEC hazard stall
//   wr_valid, rd_wb, wr_data  registered register-file write port
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int RD_WIDTH     = WB_RD_WIDTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  alu_valid,
  input  logic [RD_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  long_valid,
  input  logic [RD_WIDTH-1:0]   long_rd,
  input  logic [DATA_WIDTH-1:0] long_data,
  output logic                  long_ready,
  input  logic                  issue_long,
  input  logic [RD_WIDTH-1:0]   issue_rd,
  input  logic [RD_WIDTH-1:0]   rs1_dec,
  input  logic [RD_WIDTH-1:0]   rs2_dec,
  input  logic [DATA_WIDTH-1:0] gprs_data1,
  input  logic [DATA_WIDTH-1:0] gprs_data2,
  output logic [DATA_WIDTH-1:0] src1_data,
  output logic [DATA_WIDTH-1:0] src2_data,
  output logic                  dec_stall,
  output logic                  wr_valid,
  output logic [RD_WIDTH-1:0]   rd_wb,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [RD_WIDTH-1:0]         RD_ZERO    = RD_WIDTH'(REG_ZERO);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_r;
  logic                        alu_ready_s;
  logic                        long_ready_s;
  wb_winner_e                  winner_s;
  logic [RD_WIDTH-1:0]         win_rd_s;
  logic [DATA_WIDTH-1:0]       win_data_s;
  logic                        long_acc_s;

  // Arbitration: ALU has priority until the long source has lost STARVE_LIMIT times in a row.
  always_comb begin
    if ((starve_cnt_r == STARVE_MAX) && long_valid) begin
      alu_ready_s  = 1'b0;
      long_ready_s = 1'b1;
    end else begin
      alu_ready_s  = 1'b1;
      long_ready_s = ~alu_valid;
    end
  end

  // Winner selection from the handshakes.
  always_comb begin
    if (alu_valid && alu_ready_s) begin
      winner_s = WIN_ALU;
    end else if (long_valid && long_ready_s) begin
      winner_s = WIN_LONG;
    end else begin
      winner_s = WIN_NONE;
    end
  end

  // Winner result mux.
  always_comb begin
    case (winner_s)
      WIN_ALU: begin
        win_rd_s   = alu_rd;
        win_data_s = alu_data;
      end
      WIN_LONG: begin
        win_rd_s   = long_rd;
        win_data_s = long_data;
      end
      default: begin
        win_rd_s   = RD_ZERO;
        win_data_s = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  assign long_acc_s = (winner_s == WIN_LONG);

  // Starvation counter: counts consecutive lost cycles of a waiting long result.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      starve_cnt_r <= {STARVE_CNT_WIDTH{1'b0}};
    end else if (long_valid && !long_ready_s) begin
      starve_cnt_r <= starve_inc(starve_cnt_r, STARVE_MAX);
    end else begin
      starve_cnt_r <= {STARVE_CNT_WIDTH{1'b0}};
    end
  end

  // Writeback register; rd/data hold when nothing is accepted.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_valid <= 1'b0;
      rd_wb    <= RD_ZERO;
      wr_data  <= {DATA_WIDTH{1'b0}};
    end else if (winner_s != WIN_NONE) begin
      wr_valid <= (win_rd_s != RD_ZERO);
      rd_wb    <= win_rd_s;
      wr_data  <= win_data_s;
    end else begin
      wr_valid <= 1'b0;
      rd_wb    <= rd_wb;
      wr_data  <= wr_data;
    end
  end

  // Bypass: the register file only sees wr_data one edge later.
  always_comb begin
    if (wr_valid && (rd_wb == rs1_dec) && (rs1_dec != RD_ZERO)) begin
      src1_data = wr_data;
    end else begin
      src1_data = gprs_data1;
    end
    if (wr_valid && (rd_wb == rs2_dec) && (rs2_dec != RD_ZERO)) begin
      src2_data = wr_data;
    end else begin
      src2_data = gprs_data2;
    end
  end

  wb_scoreboard #(
    .RD_WIDTH (RD_WIDTH)
  ) u_scoreboard (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .issue_long (issue_long),
    .issue_rd   (issue_rd),
    .clr_valid  (long_acc_s),
    .clr_rd     (long_rd),
    .rs1        (rs1_dec),
    .rs2        (rs2_dec),
    .dec_stall  (dec_stall)
  );

  assign alu_ready  = alu_ready_s;
  assign long_ready = long_ready_s;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SL = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          alu_valid;
  logic [RW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          long_valid;
  logic [RW-1:0] long_rd;
  logic [DW-1:0] long_data;
  logic          long_ready;
  logic          issue_long;
  logic [RW-1:0] issue_rd;
  logic [RW-1:0] rs1_dec;
  logic [RW-1:0] rs2_dec;
  logic [DW-1:0] gprs_data1;
  logic [DW-1:0] gprs_data2;
  logic [DW-1:0] src1_data;
  logic [DW-1:0] src2_data;
  logic          dec_stall;
  logic          wr_valid;
  logic [RW-1:0] rd_wb;
  logic [DW-1:0] wr_data;

  wb_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .STARVE_LIMIT(SL)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .long_valid(long_valid), .long_rd(long_rd), .long_data(long_data), .long_ready(long_ready),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
    .gprs_data1(gprs_data1), .gprs_data2(gprs_data2),
    .src1_data(src1_data), .src2_data(src2_data),
    .dec_stall(dec_stall),
    .wr_valid(wr_valid), .rd_wb(rd_wb), .wr_data(wr_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Behavioural model state: which registers await a long result, how many
  // cycles in a row the long source has been refused, and the pending write.
  bit            busy_m [32];
  int            lost_m;
  bit            wv_m;
  logic [RW-1:0] rd_m;
  logic [DW-1:0] wd_m;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    lost_m = 0;
    wv_m   = 1'b0;
    rd_m   = '0;
    wd_m   = '0;
  endtask

  function automatic bit m_long_forced();
    return (lost_m >= SL) && long_valid;
  endfunction

  function automatic bit m_stall();
    return busy_m[rs1_dec] || busy_m[rs2_dec] || (issue_long && busy_m[issue_rd]);
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    bit forced, alu_acc, long_acc, stall;
    if (cpu_rst) begin
      model_reset();
    end else begin
      forced   = m_long_forced();
      alu_acc  = alu_valid && !forced;
      long_acc = long_valid && !alu_acc;
      stall    = m_stall();
      if (alu_acc) begin
        wv_m = (alu_rd != 0); rd_m = alu_rd; wd_m = alu_data;
      end else if (long_acc) begin
        wv_m = (long_rd != 0); rd_m = long_rd; wd_m = long_data;
      end else begin
        wv_m = 1'b0;
      end
      if (long_valid && !long_acc) lost_m = (lost_m < SL) ? lost_m + 1 : SL;
      else lost_m = 0;
      if (long_acc) busy_m[long_rd] = 1'b0;
      if (issue_long && !stall && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_all();
    bit forced;
    logic [DW-1:0] e1, e2;
    forced = m_long_forced();
    e1 = (wv_m && rd_m == rs1_dec && rs1_dec != 0) ? wd_m : gprs_data1;
    e2 = (wv_m && rd_m == rs2_dec && rs2_dec != 0) ? wd_m : gprs_data2;
    chk("alu_ready",  32'(alu_ready),  32'(!forced));
    chk("long_ready", 32'(long_ready), 32'(forced || !alu_valid));
    chk("dec_stall",  32'(dec_stall),  32'(m_stall()));
    chk("wr_valid",   32'(wr_valid),   32'(wv_m));
    chk("rd_wb",      32'(rd_wb),      32'(rd_m));
    chk("wr_data",    wr_data,         wd_m);
    chk("src1_data",  src1_data,       e1);
    chk("src2_data",  src2_data,       e2);
  endtask

  always @(negedge cpu_clk) begin
    if (chk_en && !cpu_rst) compare_all();
  end

  task automatic tick();
    @(posedge cpu_clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    long_valid = 1'b0; long_rd = '0; long_data = '0;
    issue_long = 1'b0; issue_rd = '0;
    rs1_dec = '0; rs2_dec = '0;
    gprs_data1 = 32'hA5A5_0001; gprs_data2 = 32'h5A5A_0002;
  endtask

  initial begin
    cpu_rst = 1'b1;
    idle_inputs();
    model_reset();
    tick(); tick();
    // Reset state
    chk("rst wr_valid",   32'(wr_valid),   32'd0);
    chk("rst rd_wb",      32'(rd_wb),      32'd0);
    chk("rst wr_data",    wr_data,         32'd0);
    chk("rst alu_ready",  32'(alu_ready),  32'd1);
    chk("rst long_ready", 32'(long_ready), 32'd1);
    chk("rst dec_stall",  32'(dec_stall),  32'd0);
    cpu_rst = 1'b0;
    chk_en  = 1'b1;
    tick();

    // ALU only, then bypass of the in-flight value
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    #1 chk("alu only ready", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs(); rs1_dec = 5'd5; gprs_data1 = 32'hFFFF_0000;
    #1;
    chk("alu wr_valid", 32'(wr_valid), 32'd1);
    chk("alu rd_wb",    32'(rd_wb),    32'd5);
    chk("alu wr_data",  wr_data,       32'h0000_1234);
    chk("alu bypass1",  src1_data,     32'h0000_1234);
    tick();
    #1 chk("bypass ends", src1_data, 32'hFFFF_0000);

    // Scoreboard RAW hazard and release through the bypass
    idle_inputs(); issue_long = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs(); rs2_dec = 5'd7;
    #1 chk("raw stall", 32'(dec_stall), 32'd1);
    tick();
    long_valid = 1'b1; long_rd = 5'd7; long_data = 32'h0000_DEAD;
    #1 chk("long accept ready", 32'(long_ready), 32'd1);
    tick();
    long_valid = 1'b0;
    #1;
    chk("raw released",  32'(dec_stall), 32'd0);
    chk("raw bypass2",   src2_data,      32'h0000_DEAD);
    tick();

    // Starvation: two rounds of four losses then a forced long win
    idle_inputs();
    for (int r = 0; r < 2; r++) begin
      alu_valid = 1'b1; alu_rd = 5'd1;
      long_valid = 1'b1; long_rd = 5'd2; long_data = 32'hBEEF_0000 + 32'(r);
      for (int k = 0; k < 4; k++) begin
        alu_data = 32'h100 + 32'(k);
        #1 chk("starve lose", 32'(long_ready), 32'd0);
        tick();
      end
      #1;
      chk("starve win long",  32'(long_ready), 32'd1);
      chk("starve win alu",   32'(alu_ready),  32'd0);
      tick();
      long_valid = 1'b0;
      #1;
      chk("starve wr_data", wr_data,        32'hBEEF_0000 + 32'(r));
      chk("starve alu back", 32'(alu_ready), 32'd1);
      tick();
    end

    // Register 0 handling
    idle_inputs(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    tick();
    idle_inputs(); issue_long = 1'b1; issue_rd = 5'd0;
    #1 chk("x0 alu no write", 32'(wr_valid), 32'd0);
    tick();
    idle_inputs(); long_valid = 1'b1; long_rd = 5'd0; long_data = 32'h88;
    #1;
    chk("x0 no busy",   32'(dec_stall), 32'd0);
    chk("x0 src1 raw",  src1_data,      32'hA5A5_0001);
    tick();
    idle_inputs();
    #1 chk("x0 long no write", 32'(wr_valid), 32'd0);
    tick();

    // Same-cycle set/clear on different indices, then WAW guard
    issue_long = 1'b1; issue_rd = 5'd9;
    tick();
    issue_rd = 5'd3; long_valid = 1'b1; long_rd = 5'd9; long_data = 32'h99;
    tick();
    idle_inputs(); rs1_dec = 5'd9;
    #1 chk("busy9 cleared", 32'(dec_stall), 32'd0);
    rs1_dec = 5'd3;
    #1 chk("busy3 set", 32'(dec_stall), 32'd1);
    rs1_dec = 5'd0; issue_long = 1'b1; issue_rd = 5'd3;
    #1 chk("waw stall", 32'(dec_stall), 32'd1);
    tick();
    idle_inputs(); long_valid = 1'b1; long_rd = 5'd3; long_data = 32'h33;
    tick();
    idle_inputs();
    tick();

    // Asynchronous reset mid-operation
    issue_long = 1'b1; issue_rd = 5'd10;
    tick();
    idle_inputs(); alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    tick();
    idle_inputs(); rs1_dec = 5'd10;
    #1;
    chk("pre-rst wr_valid",  32'(wr_valid),  32'd1);
    chk("pre-rst dec_stall", 32'(dec_stall), 32'd1);
    #1 cpu_rst = 1'b1;
    #1;
    chk("async wr_valid",  32'(wr_valid),  32'd0);
    chk("async rd_wb",     32'(rd_wb),     32'd0);
    chk("async wr_data",   wr_data,        32'd0);
    chk("async dec_stall", 32'(dec_stall), 32'd0);
    chk("async alu_ready", 32'(alu_ready), 32'd1);
    model_reset();
    tick();
    cpu_rst = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage between the EX/memory units and the general purpose register file. It arbitrates between the single-cycle ALU result and a long-latency result (load/mul/div), registers the winner, and drives the register-file write port (`wr_valid`, `rd_wb`, `wr_data`). It keeps a per-register busy scoreboard that stalls DEC on hazards against outstanding long-latency ops. It also bypasses the in-flight WB value onto the DEC read data, because the register file only updates at the next edge.

## Interface
- `DATA_WIDTH`, 32: result/register width.
- `RD_WIDTH`, 5: register index width.
- `STARVE_LIMIT`, 4: consecutive lost arbitration cycles before the long-latency source is forced to win (1..15).

- `cpu_clk` in 1: clock; all state updates on rising edge.
- `cpu_rst` in 1: reset, asynchronous, active-high.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in RD_WIDTH: ALU destination.
- `alu_data` in DATA_WIDTH: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle.
- `long_valid` in 1: long-latency result present; held with stable rd/data until accepted.
- `long_rd` in RD_WIDTH: long-latency destination.
- `long_data` in DATA_WIDTH: long-latency result.
- `long_ready` out 1: long-latency result accepted this cycle.
- `issue_long` in 1: DEC issues a long-latency op this cycle; only meaningful when `dec_stall`=0.
- `issue_rd` in RD_WIDTH: destination of that op.
- `rs1_dec`, `rs2_dec` in RD_WIDTH: DEC source indices.
- `gprs_data1`, `gprs_data2` in DATA_WIDTH: raw register-file read data.
- `src1_data`, `src2_data` out DATA_WIDTH: bypassed operands to DEC.
- `dec_stall` out 1: DEC must hold.
- `wr_valid` out 1, `rd_wb` out RD_WIDTH, `wr_data` out DATA_WIDTH: register-file write port, registered.

## Operation
- Arbitration, combinational:
  - If `starve_cnt` < STARVE_LIMIT: ALU wins whenever `alu_valid`=1. `alu_ready`=1 and `long_ready`=!`alu_valid`.
  - If `starve_cnt` == STARVE_LIMIT and `long_valid`=1: long wins. `long_ready`=1 and `alu_ready`=0.
- `starve_cnt`:
  - Increments when `long_valid` && !`long_ready`, saturating at STARVE_LIMIT.
  - Clears when `long_ready` && `long_valid`, or when `long_valid`=0.
- WB register, on each edge:
  - `wr_valid` <= accepted && (winner rd != 0).
  - `rd_wb`/`wr_data` <= the winner's values.
  - With no acceptance, `wr_valid` <= 0 and `rd_wb`/`wr_data` hold their previous values.
- Scoreboard `busy[31:1]`:
  - Set on `issue_long` && !`dec_stall` && `issue_rd` != 0.
  - Cleared for `long_rd` when the long result is accepted.
  - Set and clear on the same index in the same cycle: set wins.
  - `busy[0]` is constant 0.
- `dec_stall` = busy[rs1_dec] | busy[rs2_dec] | (issue_long & busy[issue_rd]). The last term is the WAW guard.
- Bypass: `src1_data` = (`wr_valid` && `rd_wb`==`rs1_dec` && `rs1_dec`!=0) ? `wr_data` : `gprs_data1`. `src2_data` is identical with rs2.

## Timing
- Result accepted in cycle N -> `wr_valid` high in N+1 -> register file holds the value from N+2. Bypass covers N+1.
- A busy bit cleared by acceptance in N drops `dec_stall` in N+1 (registered bit). The dependent instruction then reads through the bypass.
- `alu_ready`, `long_ready`, `dec_stall`, `src*_data` are combinational. `wr_*`, `busy`, `starve_cnt` are registered.
- Reset values: `wr_valid`=0, `rd_wb`=0, `wr_data`=0, all busy=0, `starve_cnt`=0. With both valids low after reset, `alu_ready`=1, `long_ready`=1, `dec_stall`=0.
- Reset asserted mid-operation clears everything immediately (asynchronous). An in-flight long result is dropped, and its source is reset by the same `cpu_rst`.
- A long source presenting rd=0 is accepted normally, but no write occurs (`wr_valid`=0).

## Structure
- Shared core package/defines: DATA_WIDTH, RD_WIDTH, the STARVE_LIMIT default, and the constant for register 0.
- Single natural sub-module: `wb_scoreboard`, which holds the busy vector, set/clear logic and the `dec_stall` hazard lookup.
- Arbiter, starve counter, WB register and bypass live in the top.

## Test plan
- ALU only: `alu_valid`=1, rd=5, data=0x1234 -> next cycle `wr_valid`=1, `rd_wb`=5, `wr_data`=0x1234. `rs1_dec`=5 in that cycle -> `src1_data`=0x1234 regardless of `gprs_data1`.
- Scoreboard: `issue_long` rd=7 -> `rs2_dec`=7 gives `dec_stall`=1. Long result rd=7, 0xDEAD accepted in N -> `dec_stall`=0 in N+1 and `src2_data`=0xDEAD.
- Starvation: `alu_valid` and `long_valid` held high -> after 4 lost cycles, the 5th cycle gives `long_ready`=1 and `alu_ready`=0. Next cycle the ALU wins again and `starve_cnt`=0.
- x0: ALU rd=0 -> `wr_valid`=0. `issue_long` rd=0 -> no busy set, and `rs1_dec`=0 never stalls or bypasses.
- Same-cycle set/clear: long result rd=9 accepted while `issue_long` rd=3 -> busy[9]=0, busy[3]=1. WAW: `issue_long` rd=3 with busy[3]=1 -> `dec_stall`=1.
- Reset: assert `cpu_rst` with busy bits set and `wr_valid`=1 -> all outputs are at their reset values without waiting for a clock edge.
